// File: rtl/spi_ram_slave_burst.sv
// SPI slave with an integrated single-port RAM. Frames carry a 2-bit opcode, then
// an address, burst write data, or dummy bits followed by burst read data on MISO.
module spi_ram_slave_burst #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8,
   parameter int MEM_DEPTH  = 256,
   parameter bit AUTO_INC   = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic SS_n,
   input  logic MOSI,
   output logic MISO,
   output logic busy,
   output logic err
);

   localparam int SW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
   localparam int CW = $clog2(SW + 1);
   localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_WIDTH - 1);
   localparam logic [CW-1:0] ADDR_DONE = CW'(ADDR_WIDTH);
   localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE, CMD, WR_ADDR, WR_DATA, RD_ADDR, RD_DUMMY, RD_TURN, RD_SHIFT
   } state_t;

   function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
      return (int'(a) < MEM_DEPTH);
   endfunction

   function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a);
      if (int'(a) >= MEM_DEPTH - 1) begin
         return '0;
      end else begin
         return a + ADDR_WIDTH'(1);
      end
   endfunction

   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

   state_t                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  op_q, op_d;
   logic [SW-1:0]         sh_q, sh_d;
   logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
   logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
   logic                  miso_q, miso_d;
   logic                  err_q, err_d;
   logic                  busy_q, busy_d;
   logic                  armed_q, armed_d;
   logic                  mem_we_s;
   logic [DATA_WIDTH-1:0] mem_wdata_s;

   // Next-state, datapath and output decode for the frame FSM.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      op_d        = op_q;
      sh_d        = sh_q;
      wr_addr_d   = wr_addr_q;
      rd_addr_d   = rd_addr_q;
      miso_d      = 1'b0;
      err_d       = 1'b0;
      armed_d     = armed_q | SS_n;
      mem_we_s    = 1'b0;
      mem_wdata_s = {sh_q[DATA_WIDTH-2:0], MOSI};
      if (SS_n) begin
         state_d = IDLE;
         cnt_d   = '0;
         if (state_q == WR_DATA && cnt_q != '0) begin
            err_d = 1'b1;
         end else begin
            err_d = 1'b0;
         end
      end else begin
         case (state_q)
            // armed_q keeps a frame cut by reset from restarting until SS_n toggles
            IDLE: begin
               if (armed_q) begin
                  state_d = CMD;
                  cnt_d   = '0;
               end else begin
                  state_d = IDLE;
               end
            end
            CMD: begin
               if (cnt_q == '0) begin
                  op_d  = MOSI;
                  cnt_d = CW'(1);
               end else begin
                  cnt_d = '0;
                  case ({op_q, MOSI})
                     2'b00:   state_d = WR_ADDR;
                     2'b01:   state_d = WR_DATA;
                     2'b10:   state_d = RD_ADDR;
                     default: state_d = RD_DUMMY;
                  endcase
               end
            end
            WR_ADDR, RD_ADDR: begin
               if (cnt_q != ADDR_DONE) begin
                  sh_d  = {sh_q[SW-2:0], MOSI};
                  cnt_d = cnt_q + CW'(1);
                  if (cnt_q == ADDR_LAST && state_q == WR_ADDR) begin
                     wr_addr_d = {sh_q[ADDR_WIDTH-2:0], MOSI};
                  end else if (cnt_q == ADDR_LAST) begin
                     rd_addr_d = {sh_q[ADDR_WIDTH-2:0], MOSI};
                  end else begin
                     wr_addr_d = wr_addr_q;
                  end
               end else begin
                  cnt_d = cnt_q;
               end
            end
            WR_DATA: begin
               sh_d = {sh_q[SW-2:0], MOSI};
               if (cnt_q == DATA_LAST) begin
                  cnt_d = '0;
                  if (in_range(wr_addr_q)) begin
                     mem_we_s = 1'b1;
                  end else begin
                     err_d = 1'b1;
                  end
                  if (AUTO_INC) begin
                     wr_addr_d = next_addr(wr_addr_q);
                  end else begin
                     wr_addr_d = wr_addr_q;
                  end
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            RD_DUMMY: begin
               if (cnt_q == DATA_LAST) begin
                  state_d = RD_TURN;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            RD_TURN: begin
               state_d = RD_SHIFT;
               cnt_d   = '0;
               if (in_range(rd_addr_q)) begin
                  sh_d = SW'(mem[rd_addr_q]);
               end else begin
                  sh_d  = '0;
                  err_d = 1'b1;
               end
            end
            RD_SHIFT: begin
               miso_d = sh_q[DATA_WIDTH-1];
               sh_d   = {sh_q[SW-2:0], 1'b0};
               if (cnt_q == DATA_LAST) begin
                  state_d = RD_TURN;
                  cnt_d   = '0;
                  if (AUTO_INC) begin
                     rd_addr_d = next_addr(rd_addr_q);
                  end else begin
                     rd_addr_d = rd_addr_q;
                  end
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            default: state_d = IDLE;
         endcase
      end
      busy_d = (state_d != IDLE);
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         op_q      <= 1'b0;
         sh_q      <= '0;
         wr_addr_q <= '0;
         rd_addr_q <= '0;
         miso_q    <= 1'b0;
         err_q     <= 1'b0;
         busy_q    <= 1'b0;
         armed_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         op_q      <= op_d;
         sh_q      <= sh_d;
         wr_addr_q <= wr_addr_d;
         rd_addr_q <= rd_addr_d;
         miso_q    <= miso_d;
         err_q     <= err_d;
         busy_q    <= busy_d;
         armed_q   <= armed_d;
      end
   end

   // RAM write port; contents survive reset.
   always_ff @(posedge clk) begin
      if (mem_we_s) begin
         mem[wr_addr_q] <= mem_wdata_s;
      end
   end

   assign MISO = miso_q;
   assign busy = busy_q;
   assign err  = err_q;

endmodule

// File: tb/tb_spi_ram_slave_burst.sv
// Randomised bench: three configurations (default, no auto-increment, 200-word RAM)
// share the SPI pins and are each compared with a per-configuration memory model.
module tb_spi_ram_slave_burst;

   logic       clk = 1'b0;
   logic       rst;
   logic       ss_n;
   logic       mosi;
   logic [2:0] miso_w, busy_w, err_w;

   always #5 clk = ~clk;

   spi_ram_slave_burst u_dut0 (.clk(clk), .rst(rst), .SS_n(ss_n), .MOSI(mosi),
      .MISO(miso_w[0]), .busy(busy_w[0]), .err(err_w[0]));
   spi_ram_slave_burst #(.AUTO_INC(1'b0)) u_dut1 (.clk(clk), .rst(rst), .SS_n(ss_n),
      .MOSI(mosi), .MISO(miso_w[1]), .busy(busy_w[1]), .err(err_w[1]));
   spi_ram_slave_burst #(.MEM_DEPTH(200)) u_dut2 (.clk(clk), .rst(rst), .SS_n(ss_n),
      .MOSI(mosi), .MISO(miso_w[2]), .busy(busy_w[2]), .err(err_w[2]));

   int vec_cnt  = 0;
   int miss_cnt = 0;

   int         depth_m [3] = '{256, 256, 200};
   bit         inc_m   [3] = '{1'b1, 1'b0, 1'b1};
   logic [7:0] ram_m   [3][256];
   bit         known_m [3][256];
   int         wa_m    [3];
   int         ra_m    [3];

   bit         tx_q [$];
   logic [2:0] cap_miso [128];
   int         err_seen [3];
   logic [2:0] post_busy;
   logic [7:0] wbuf [8];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec_cnt++;
      if (obs !== exp) begin
         miss_cnt++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int nxt(input int d, input int a);
      return (a >= depth_m[d] - 1) ? 0 : a + 1;
   endfunction

   task automatic push_bits(input logic [31:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) tx_q.push_back(v[i]);
   endtask

   // drives one frame; returns with SS_n still low once cycle stop_at is sampled
   task automatic do_frame(input logic [1:0] op, input int stop_at);
      int len;
      len = 3 + tx_q.size();
      for (int d = 0; d < 3; d++) err_seen[d] = 0;
      @(negedge clk);
      ss_n = 1'b0;
      mosi = 1'b0;
      for (int c = 0; c < len; c++) begin
         @(negedge clk);
         if (c < 128) cap_miso[c] = miso_w;
         for (int d = 0; d < 3; d++) if (err_w[d]) err_seen[d]++;
         if (c == stop_at) return;
         if (c + 1 == len) begin
            ss_n = 1'b1;
            mosi = 1'b0;
         end else if (c + 1 <= 2) begin
            mosi = op[1-c];
         end else begin
            mosi = tx_q[c-2];
         end
      end
      @(negedge clk);
      post_busy = busy_w;
      for (int d = 0; d < 3; d++) if (err_w[d]) err_seen[d]++;
      @(negedge clk);
      for (int d = 0; d < 3; d++) if (err_w[d]) err_seen[d]++;
   endtask

   task automatic f_addr(input bit is_rd, input int a);
      tx_q.delete();
      push_bits(32'(a), 8);
      do_frame(is_rd ? 2'b10 : 2'b00, -1);
      for (int d = 0; d < 3; d++) begin
         if (is_rd) ra_m[d] = a;
         else       wa_m[d] = a;
         chk($sformatf("addr_err[%0d]", d), 32'(err_seen[d]), 32'd0);
      end
   endtask

   task automatic f_wr(input int n, input int part);
      int a, e;
      tx_q.delete();
      for (int i = 0; i < n; i++) push_bits(32'(wbuf[i]), 8);
      for (int i = 0; i < part; i++) tx_q.push_back($urandom_range(0, 1) != 0);
      do_frame(2'b01, -1);
      for (int d = 0; d < 3; d++) begin
         a = wa_m[d];
         e = 0;
         for (int i = 0; i < n; i++) begin
            if (a < depth_m[d]) begin
               ram_m[d][a]   = wbuf[i];
               known_m[d][a] = 1'b1;
            end else begin
               e++;
            end
            if (inc_m[d]) a = nxt(d, a);
         end
         wa_m[d] = a;
         if (part > 0) begin
            e++;
            chk($sformatf("abort_busy[%0d]", d), 32'(post_busy[d]), 32'd0);
         end
         chk($sformatf("wr_err[%0d]", d), 32'(err_seen[d]), 32'(e));
      end
   endtask

   task automatic f_rd(input int n);
      int a, e;
      logic [7:0] w;
      tx_q.delete();
      for (int i = 0; i < 8 + 9 * n; i++) tx_q.push_back($urandom_range(0, 1) != 0);
      do_frame(2'b11, -1);
      for (int d = 0; d < 3; d++) begin
         a = ra_m[d];
         e = 0;
         for (int i = 0; i < n; i++) begin
            w = 8'h00;
            for (int k = 0; k < 8; k++) w = {w[6:0], cap_miso[12+9*i+k][d]};
            if (a >= depth_m[d]) begin
               e++;
               chk($sformatf("rd_oor[%0d]", d), 32'(w), 32'd0);
            end else if (known_m[d][a]) begin
               chk($sformatf("rd_data[%0d]@%0h", d, a), 32'(w), 32'(ram_m[d][a]));
            end
            if (inc_m[d]) a = nxt(d, a);
         end
         ra_m[d] = a;
         chk($sformatf("rd_err[%0d]", d), 32'(err_seen[d]), 32'(e));
      end
   endtask

   function automatic int rand_addr();
      case ($urandom_range(0, 2))
         0:       return 32'hC4 + $urandom_range(0, 3);
         1:       return 32'hFC + $urandom_range(0, 3);
         default: return $urandom_range(0, 3);
      endcase
   endfunction

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst  = 1'b1;
      ss_n = 1'b1;
      mosi = 1'b0;
      for (int d = 0; d < 3; d++) begin
         wa_m[d] = 0;
         ra_m[d] = 0;
      end
      repeat (3) @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("rst_miso[%0d]", d), 32'(miso_w[d]), 32'd0);
         chk($sformatf("rst_busy[%0d]", d), 32'(busy_w[d]), 32'd0);
         chk($sformatf("rst_err[%0d]", d), 32'(err_w[d]), 32'd0);
      end
      rst = 1'b0;

      // write/read round trip
      f_addr(0, 8'h3C); wbuf[0] = 8'hA5; f_wr(1, 0);
      f_addr(1, 8'h3C); f_rd(1);

      // burst across the top of memory
      f_addr(0, 8'hFE); wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33; f_wr(3, 0);
      f_addr(1, 8'hFE); f_rd(3);

      // aborted word leaves the target untouched
      f_addr(0, 8'h20); wbuf[0] = 8'h5A; f_wr(1, 0);
      f_addr(0, 8'h20); f_wr(0, 4);
      f_addr(1, 8'h20); f_rd(1);

      // fixed-address burst versus incrementing burst
      f_addr(0, 8'h11); wbuf[0] = 8'h77; f_wr(1, 0);
      f_addr(0, 8'h10); wbuf[0] = 8'h01; wbuf[1] = 8'h02; f_wr(2, 0);
      f_addr(1, 8'h10); f_rd(1);
      f_addr(1, 8'h11); f_rd(1);

      // beyond the 200-word RAM
      f_addr(0, 8'hD0); wbuf[0] = 8'h55; f_wr(1, 0);
      f_addr(1, 8'hD0); f_rd(1);

      // reset in the middle of a read burst
      f_addr(0, 8'h00); wbuf[0] = 8'hC3; f_wr(1, 0);
      f_addr(1, 8'h3C);
      tx_q.delete();
      for (int i = 0; i < 17; i++) tx_q.push_back(1'b0);
      do_frame(2'b11, 12);
      for (int d = 0; d < 3; d++) chk($sformatf("pre_rst_miso[%0d]", d), 32'(miso_w[d]), 32'd1);
      #2 rst = 1'b1;
      #1;
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("async_miso[%0d]", d), 32'(miso_w[d]), 32'd0);
         chk($sformatf("async_busy[%0d]", d), 32'(busy_w[d]), 32'd0);
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      for (int d = 0; d < 3; d++) chk($sformatf("held_busy[%0d]", d), 32'(busy_w[d]), 32'd0);
      ss_n = 1'b1;
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         wa_m[d] = 0;
         ra_m[d] = 0;
      end
      f_rd(1);

      // random frames
      for (int it = 0; it < 40; it++) begin
         case ($urandom_range(0, 3))
            0: f_addr(0, rand_addr());
            1: begin
               for (int i = 0; i < 8; i++) wbuf[i] = 8'($urandom);
               f_wr($urandom_range(1, 4), ($urandom_range(0, 4) == 0) ? $urandom_range(1, 7) : 0);
            end
            2: f_addr(1, rand_addr());
            default: f_rd($urandom_range(1, 3));
         endcase
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end

endmodule
